shade_combine: RTL and testbench

SHADE_COMBINE -- requirements
Module: shade_combine

---
 rtl/shade_combine_pkg.sv | 70 +++++++
 rtl/shade_combine_if.sv | 22 ++
 rtl/shade_combine_color_mul.sv | 25 ++
 rtl/shade_combine.sv | 136 +++++++++++++
 tb/tb_shade_combine.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shade_combine_pkg.sv
// Shared RayCore types for the shading stage: fragment/result structs, FSM state enum
// and the N.L clamp helper.
package shade_combine_pkg;

  typedef logic signed [15:0] fixed16_t;

  typedef struct packed {
    fixed16_t x;
    fixed16_t y;
    fixed16_t z;
  } FixedNorm3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color3;

  typedef enum logic [1:0] {
    ST_None       = 2'd0,
    ST_Diffuse    = 2'd1,
    ST_Reflective = 2'd2
  } surface_e;

  typedef enum logic [1:0] {
    SHC_Init    = 2'd0,
    SHC_Diffuse = 2'd1,
    SHC_Blend   = 2'd2,
    SHC_Done    = 2'd3
  } ShadeState;

  typedef struct packed {
    Color3       Color;
    Color3       LastColor;
    FixedNorm3   Normal;
    surface_e    SurfaceType;
    logic [2:0]  BounceLevel;
    logic        bShadow;
    logic [11:0] x;
    logic [11:0] y;
    FixedNorm3   HitPos;
    FixedNorm3   ViewDir;
    logic [15:0] PI;
  } ShadowOutputData;

  typedef struct packed {
    FixedNorm3 LightDir;
    Color3     ClearColor;
  } RenderState;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    Color3       Color;
    logic        bReflect;
    logic [2:0]  BounceLevel;
    FixedNorm3   HitPos;
    FixedNorm3   ViewDir;
    FixedNorm3   Normal;
    logic [15:0] PI;
  } ShadeOutputData;

  // Clamp a 2.14 dot product to the unit range [0, 1.0 = 16'h4000].
  function automatic logic [14:0] clamp_unit(input logic signed [33:0] v);
    if (v < 34'sd0) return 15'd0;
    if (v > 34'sd16384) return 15'd16384;
    return v[14:0];
  endfunction

endpackage

// File: rtl/shade_combine_if.sv
// Fragment-in / shaded-result-out bus of the shading stage.
interface shade_combine_if;
  import shade_combine_pkg::*;

  logic            add_input;
  ShadowOutputData input_data;
  RenderState      rs;
  logic            output_fifo_full;
  logic            fifo_full;
  logic            valid;
  ShadeOutputData  out;

  modport master (
    output add_input, input_data, rs, output_fifo_full,
    input  fifo_full, valid, out
  );

  modport slave (
    input  add_input, input_data, rs, output_fifo_full,
    output fifo_full, valid, out
  );
endinterface

// File: rtl/shade_combine_color_mul.sv
// Per-channel intensity scale; SHADE_BOUNCE_BLEND_EN adds averaging with the previous
// bounce colour when i_blend is set.
module shade_color_mul (
  input  logic [7:0] i_color,
  input  logic [8:0] i_intensity,
  input  logic [7:0] i_last,
  input  logic       i_blend,
  output logic [7:0] o_color
);
  logic [16:0] w_scaled;
  logic [7:0]  w_shaded;

  assign w_scaled = 17'(i_color) * 17'(i_intensity);
  assign w_shaded = 8'(w_scaled >> 8);

`ifdef SHADE_BOUNCE_BLEND_EN
  logic [8:0] w_sum;
  assign w_sum   = 9'(i_last) + 9'(w_shaded);
  assign o_color = i_blend ? 8'(w_sum >> 1) : w_shaded;
`else
  logic w_unused_blend;
  assign w_unused_blend = ^{i_last, i_blend};
  assign o_color        = w_shaded;
`endif
endmodule

// File: rtl/shade_combine.sv
// Shading stage: single-entry input buffer, N.L diffuse + ambient, reflect decision.
// Optional bounce colour blend via SHADE_BOUNCE_BLEND_EN (see shade_color_mul).
module shade_combine
  import shade_combine_pkg::*;
#(
  parameter logic [7:0]  AMBIENT    = 8'd32,
  parameter int unsigned MAX_BOUNCE = 2
) (
  input  logic           clk,
  input  logic           resetn,
  shade_combine_if.slave bus
);
  ShadeState       r_state;
  ShadowOutputData r_buf;
  logic            r_fifo_full;
  ShadowOutputData r_work;
  logic [14:0]     r_ndotl;
  ShadeOutputData  r_res;
  ShadeOutputData  r_out;
  logic            r_valid;

  logic signed [33:0] w_nx, w_ny, w_nz, w_lx, w_ly, w_lz, w_dot;
  logic [14:0]        w_ndotl;
  logic [8:0]         w_span, w_lit, w_intensity;
  logic [22:0]        w_prod;
  logic [7:0]         w_sh_r, w_sh_g, w_sh_b;
  logic               w_blend, w_reflect;
  ShadeOutputData     w_result, w_clear_res;

  assign bus.fifo_full = r_fifo_full;
  assign bus.valid     = r_valid;
  assign bus.out       = r_out;

  assign w_nx    = 34'(r_work.Normal.x);
  assign w_ny    = 34'(r_work.Normal.y);
  assign w_nz    = 34'(r_work.Normal.z);
  assign w_lx    = 34'(bus.rs.LightDir.x);
  assign w_ly    = 34'(bus.rs.LightDir.y);
  assign w_lz    = 34'(bus.rs.LightDir.z);
  assign w_dot   = (w_nx * w_lx + w_ny * w_ly + w_nz * w_lz) >>> 14;
  assign w_ndotl = clamp_unit(w_dot);

  // Direct light fills the headroom above ambient so full exposure reaches exactly 256.
  assign w_span      = 9'd256 - {1'b0, AMBIENT};
  assign w_prod      = 23'(r_ndotl) * 23'(w_span);
  assign w_lit       = 9'(w_prod >> 14);
  assign w_intensity = {1'b0, AMBIENT} + (r_work.bShadow ? 9'd0 : w_lit);
  assign w_blend     = (r_work.BounceLevel != 3'd0);

  shade_color_mul u_mul_r (.i_color(r_work.Color.r), .i_intensity(w_intensity),
                           .i_last(r_work.LastColor.r), .i_blend(w_blend), .o_color(w_sh_r));
  shade_color_mul u_mul_g (.i_color(r_work.Color.g), .i_intensity(w_intensity),
                           .i_last(r_work.LastColor.g), .i_blend(w_blend), .o_color(w_sh_g));
  shade_color_mul u_mul_b (.i_color(r_work.Color.b), .i_intensity(w_intensity),
                           .i_last(r_work.LastColor.b), .i_blend(w_blend), .o_color(w_sh_b));

  assign w_reflect = (r_work.SurfaceType == ST_Reflective) &&
                     ({29'd0, r_work.BounceLevel} < MAX_BOUNCE);

  always_comb begin
    w_result             = '0;
    w_result.x           = r_work.x;
    w_result.y           = r_work.y;
    w_result.Color       = '{r: w_sh_r, g: w_sh_g, b: w_sh_b};
    w_result.bReflect    = w_reflect;
    w_result.BounceLevel = w_reflect ? r_work.BounceLevel + 3'd1 : r_work.BounceLevel;
    w_result.HitPos      = r_work.HitPos;
    w_result.ViewDir     = r_work.ViewDir;
    w_result.Normal      = r_work.Normal;
    w_result.PI          = r_work.PI;
  end

  always_comb begin
    w_clear_res             = '0;
    w_clear_res.x           = r_buf.x;
    w_clear_res.y           = r_buf.y;
    w_clear_res.Color       = bus.rs.ClearColor;
    w_clear_res.bReflect    = 1'b0;
    w_clear_res.BounceLevel = r_buf.BounceLevel;
    w_clear_res.HitPos      = r_buf.HitPos;
    w_clear_res.ViewDir     = r_buf.ViewDir;
    w_clear_res.Normal      = r_buf.Normal;
    w_clear_res.PI          = r_buf.PI;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= SHC_Init;
      r_buf       <= '0;
      r_fifo_full <= 1'b0;
      r_work      <= '0;
      r_ndotl     <= '0;
      r_res       <= '0;
      r_out       <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Capture needs an empty buffer and the Init drain needs a full one, so the two
      // fifo_full updates never collide; an add_input on the drain edge is dropped.
      if (bus.add_input && !r_fifo_full) begin
        r_buf       <= bus.input_data;
        r_fifo_full <= 1'b1;
      end
      case (r_state)
        SHC_Init: begin
          if (r_fifo_full) begin
            r_fifo_full <= 1'b0;
            r_work      <= r_buf;
            if (r_buf.SurfaceType == ST_None) begin
              r_res   <= w_clear_res;
              r_state <= SHC_Done;
            end else begin
              r_state <= SHC_Diffuse;
            end
          end
        end
        SHC_Diffuse: begin
          r_ndotl <= w_ndotl;
          r_state <= SHC_Blend;
        end
        SHC_Blend: begin
          r_res   <= w_result;
          r_state <= SHC_Done;
        end
        SHC_Done: begin
          if (!bus.output_fifo_full) begin
            r_out   <= r_res;
            r_valid <= 1'b1;
            r_state <= SHC_Init;
          end
        end
        default: r_state <= SHC_Init;
      endcase
    end
  end
endmodule

// File: tb/tb_shade_combine.sv
// Self-checking bench for shade_combine against an integer-arithmetic reference model.
module tb_shade_combine;
  import shade_combine_pkg::*;

  localparam int AMB  = 32;
  localparam int MAXB = 2;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shade_combine_if bus ();

  shade_combine #(.AMBIENT(8'd32), .MAX_BOUNCE(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
    $fatal(1, "timeout");
  end

  function automatic ShadeOutputData ref_model(input ShadowOutputData f, input RenderState r);
    ShadeOutputData o;
    longint dot, ndl;
    int inten;
    int src[3], last[3], ch[3];
    o = '0;
    o.x = f.x; o.y = f.y; o.HitPos = f.HitPos; o.ViewDir = f.ViewDir;
    o.Normal = f.Normal; o.PI = f.PI;
    o.BounceLevel = f.BounceLevel;
    if (f.SurfaceType == ST_None) begin
      o.Color = r.ClearColor;
      return o;
    end
    dot = longint'(f.Normal.x) * longint'(r.LightDir.x) +
          longint'(f.Normal.y) * longint'(r.LightDir.y) +
          longint'(f.Normal.z) * longint'(r.LightDir.z);
    ndl = dot >>> 14;
    if (ndl < 0) ndl = 0;
    if (ndl > 16384) ndl = 16384;
    inten = AMB + (f.bShadow ? 0 : int'((ndl * (256 - AMB)) / 16384));
    src  = '{int'(f.Color.r), int'(f.Color.g), int'(f.Color.b)};
    last = '{int'(f.LastColor.r), int'(f.LastColor.g), int'(f.LastColor.b)};
    for (int i = 0; i < 3; i++) begin
      ch[i] = (src[i] * inten) / 256;
`ifdef SHADE_BOUNCE_BLEND_EN
      if (f.BounceLevel > 0) ch[i] = (last[i] + ch[i]) / 2;
`endif
    end
    o.Color.r = 8'(ch[0]); o.Color.g = 8'(ch[1]); o.Color.b = 8'(ch[2]);
    o.bReflect = (f.SurfaceType == ST_Reflective) && (int'(f.BounceLevel) < MAXB);
    if (o.bReflect) o.BounceLevel = f.BounceLevel + 3'd1;
    return o;
  endfunction

  function automatic ShadowOutputData make_frag(input int cr, input int cg, input int cb,
                                                input surface_e st, input int bounce,
                                                input bit shadow);
    ShadowOutputData f;
    f.Color       = '{r: 8'(cr), g: 8'(cg), b: 8'(cb)};
    f.LastColor   = '{r: 8'd100, g: 8'd100, b: 8'd100};
    f.Normal      = '{x: 16'sh0000, y: 16'sh4000, z: 16'sh0000};
    f.SurfaceType = st;
    f.BounceLevel = 3'(bounce);
    f.bShadow     = shadow;
    f.x = 12'($urandom); f.y = 12'($urandom);
    f.HitPos  = 48'({$urandom, $urandom});
    f.ViewDir = 48'({$urandom, $urandom});
    f.PI = 16'($urandom);
    return f;
  endfunction

  function automatic ShadowOutputData rand_frag(input bit allow_none);
    ShadowOutputData f;
    f = make_frag(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  surface_e'(2'(allow_none ? $urandom_range(0, 2) : $urandom_range(1, 2))),
                  int'($urandom_range(0, 3)), 1'($urandom));
    f.LastColor = 24'($urandom);
    case ($urandom_range(0, 3))
      0: f.Normal = 48'({$urandom, $urandom});
      1: f.Normal = '{x: 16'sh2d41, y: 16'sh2d41, z: 16'sh0000};
      2: f.Normal = '{x: 16'sh0000, y: -16'sh4000, z: 16'sh0000};
      default: f.Normal = '{x: 16'sh0000, y: 16'sh4000, z: 16'sh0000};
    endcase
    return f;
  endfunction

  function automatic RenderState rand_rs();
    RenderState r;
    r.ClearColor = 24'($urandom);
    if ($urandom_range(0, 1) == 1) r.LightDir = 48'({$urandom, $urandom});
    else r.LightDir = '{x: 16'sh0000, y: 16'sh4000, z: 16'sh0000};
    return r;
  endfunction

  task automatic offer(input ShadowOutputData f);
    @(negedge clk);
    bus.input_data = f;
    bus.add_input  = 1'b1;
    @(posedge clk);
    #1;
    bus.add_input  = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc, output ShadeOutputData o);
    cyc = -1;
    o   = '0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        cyc = k;
        o   = bus.out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ShadowOutputData f;
    ShadeOutputData  o, e;
    int cyc;
    RenderState r;
    r = '0; r.LightDir = '{x: 16'sh0000, y: 16'sh4000, z: 16'sh0000};
    bus.rs = r;
    #12;
    n_checks++; if (bus.fifo_full !== 1'b0) begin n_errors++; $display("FAIL reset_fifo_full: got %b expected 0", bus.fifo_full); end
    n_checks++; if (bus.valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    n_checks++; if (bus.out !== '0) begin n_errors++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    @(negedge clk);
    resetn = 1'b1;
    f = make_frag(60, 70, 80, ST_Diffuse, 0, 1'b0);
    bus.input_data = f;
    bus.add_input  = 1'b1;
    @(posedge clk);
    #1;
    bus.add_input = 1'b0;
    n_checks++; if (bus.fifo_full !== 1'b1) begin n_errors++; $display("FAIL first_accept: fifo_full got %b expected 1", bus.fifo_full); end
    e = ref_model(f, r);
    wait_valid(12, cyc, o);
    n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL first_latency: got %0d expected 4", cyc); end
    n_checks++; if (o !== e) begin n_errors++; $display("FAIL first_out: got %h expected %h", o, e); end
  endtask

  task automatic test_lit_and_shadow();
    ShadowOutputData f;
    ShadeOutputData  o;
    int cyc;
    f = make_frag(200, 100, 50, ST_Diffuse, 0, 1'b0);
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (cyc !== 4) begin n_errors++; $display("FAIL lit_latency: got %0d expected 4", cyc); end
    n_checks++; if (o.Color !== 24'hC86432) begin n_errors++; $display("FAIL lit_color: got %h expected c86432", o.Color); end
    n_checks++; if (o !== ref_model(f, bus.rs)) begin n_errors++; $display("FAIL lit_out: got %h expected %h", o, ref_model(f, bus.rs)); end
    @(posedge clk); #1;
    n_checks++; if (bus.valid !== 1'b0) begin n_errors++; $display("FAIL valid_pulse_width: got %b expected 0", bus.valid); end
    f.bShadow = 1'b1;
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (o.Color !== 24'h190C06) begin n_errors++; $display("FAIL shadow_color: got %h expected 190c06", o.Color); end
    n_checks++; if (o.bReflect !== 1'b0) begin n_errors++; $display("FAIL shadow_reflect: got %b expected 0", o.bReflect); end
  endtask

  task automatic test_none();
    ShadowOutputData f;
    ShadeOutputData  o;
    int cyc;
    bus.rs.ClearColor = '{r: 8'd10, g: 8'd20, b: 8'd30};
    f = make_frag(200, 100, 50, ST_None, 1, 1'b0);
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (cyc !== 2) begin n_errors++; $display("FAIL none_latency: got %0d expected 2", cyc); end
    n_checks++; if (o.Color !== 24'h0A141E) begin n_errors++; $display("FAIL none_color: got %h expected 0a141e", o.Color); end
    n_checks++; if (o.bReflect !== 1'b0) begin n_errors++; $display("FAIL none_reflect: got %b expected 0", o.bReflect); end
    n_checks++; if (o.PI !== f.PI || o.x !== f.x) begin n_errors++; $display("FAIL none_passthru: got %h/%h expected %h/%h", o.PI, o.x, f.PI, f.x); end
  endtask

  task automatic test_reflect();
    ShadowOutputData f;
    ShadeOutputData  o;
    int cyc;
    logic [23:0] exp_c;
`ifdef SHADE_BOUNCE_BLEND_EN
    exp_c = 24'h969696;
`else
    exp_c = 24'hC8C8C8;
`endif
    f = make_frag(200, 200, 200, ST_Reflective, 1, 1'b0);
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (o.Color !== exp_c) begin n_errors++; $display("FAIL reflect_color: got %h expected %h", o.Color, exp_c); end
    n_checks++; if (o.bReflect !== 1'b1) begin n_errors++; $display("FAIL reflect_flag: got %b expected 1", o.bReflect); end
    n_checks++; if (o.BounceLevel !== 3'd2) begin n_errors++; $display("FAIL reflect_bounce: got %0d expected 2", o.BounceLevel); end
    f.BounceLevel = 3'd2;
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (o.bReflect !== 1'b0 || o.BounceLevel !== 3'd2) begin n_errors++; $display("FAIL reflect_max_bounce: got %b/%0d expected 0/2", o.bReflect, o.BounceLevel); end
  endtask

  task automatic test_clamp();
    ShadowOutputData f;
    ShadeOutputData  o;
    int cyc;
    f = make_frag(255, 128, 1, ST_Diffuse, 0, 1'b0);
    f.Normal = '{x: 16'sh0000, y: 16'sh7fff, z: 16'sh0000};
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (o.Color !== 24'hFF8001) begin n_errors++; $display("FAIL clamp_high: got %h expected ff8001", o.Color); end
    f.Normal = '{x: 16'sh0000, y: -16'sh4000, z: 16'sh0000};
    offer(f);
    wait_valid(12, cyc, o);
    n_checks++; if (o.Color !== 24'h1F1000) begin n_errors++; $display("FAIL clamp_low: got %h expected 1f1000", o.Color); end
  endtask

  task automatic test_random();
    ShadowOutputData f;
    ShadeOutputData  o, e;
    int cyc, exp_cyc;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.rs = rand_rs();
      f = rand_frag(1'b1);
      e = ref_model(f, bus.rs);
      exp_cyc = (f.SurfaceType == ST_None) ? 2 : 4;
      offer(f);
      wait_valid(12, cyc, o);
      n_checks++; if (cyc !== exp_cyc) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, cyc, exp_cyc); end
      n_checks++; if (o !== e) begin n_errors++; $display("FAIL rand_out[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    ShadeOutputData exp_q[$];
    int n = 12;
    @(negedge clk);
    bus.rs = rand_rs();
    fork
      begin
        ShadowOutputData f;
        int guard;
        for (int i = 0; i < n; i++) begin
          f = rand_frag(1'b0);
          @(negedge clk);
          guard = 0;
          while (bus.fifo_full && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          bus.input_data = f;
          bus.add_input  = 1'b1;
          @(posedge clk);
          #1;
          bus.add_input = 1'b0;
          exp_q.push_back(ref_model(f, bus.rs));
        end
      end
      begin
        ShadeOutputData e;
        int got = 0, last = -1, t = 0;
        while (got < n && t < 300) begin
          @(posedge clk);
          #1;
          t++;
          if (bus.valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++; if (bus.out !== e) begin n_errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", got, bus.out, e); end
            if (last >= 0) begin
              n_checks++; if (t - last !== 4) begin n_errors++; $display("FAIL b2b_interval[%0d]: got %0d expected 4", got, t - last); end
            end
            last = t;
            got++;
          end
        end
        n_checks++; if (got !== n) begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", got, n); end
      end
    join
  endtask

  task automatic test_backpressure();
    ShadowOutputData fa, fb, fc;
    ShadeOutputData  o, o0;
    int cyc, bad;
    fa = rand_frag(1'b0);
    fb = rand_frag(1'b0);
    fc = rand_frag(1'b0);
    fc.PI = ~fb.PI;
    bus.output_fifo_full = 1'b1;
    offer(fa);
    repeat (3) @(posedge clk);
    offer(fb);
    o0 = bus.out;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.input_data = fc;
        bus.add_input  = 1'b1;
      end else begin
        bus.add_input = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.valid !== 1'b0 || bus.out !== o0 || bus.fifo_full !== 1'b1) bad++;
    end
    bus.add_input = 1'b0;
    n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL stall_hold: %0d bad cycles, expected 0", bad); end
    @(negedge clk);
    bus.output_fifo_full = 1'b0;
    wait_valid(12, cyc, o);
    n_checks++; if (cyc !== 1 || o !== ref_model(fa, bus.rs)) begin n_errors++; $display("FAIL stall_first: got %h after %0d expected %h after 1", o, cyc, ref_model(fa, bus.rs)); end
    wait_valid(12, cyc, o);
    n_checks++; if (cyc !== 4 || o !== ref_model(fb, bus.rs)) begin n_errors++; $display("FAIL stall_second: got %h after %0d expected %h after 4", o, cyc, ref_model(fb, bus.rs)); end
    wait_valid(10, cyc, o);
    n_checks++; if (cyc !== -1) begin n_errors++; $display("FAIL stall_ignored: got extra output %h, expected none", o); end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    offer(rand_frag(1'b0));
    offer(rand_frag(1'b0));
    resetn = 1'b0;
    #2;
    n_checks++; if (bus.fifo_full !== 1'b0) begin n_errors++; $display("FAIL midreset_fifo_full: got %b expected 0", bus.fifo_full); end
    n_checks++; if (bus.out !== '0 || bus.valid !== 1'b0) begin n_errors++; $display("FAIL midreset_out: got %h/%b expected 0/0", bus.out, bus.valid); end
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL midreset_valid: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    resetn               = 1'b0;
    bus.add_input        = 1'b0;
    bus.input_data       = '0;
    bus.rs               = '0;
    bus.output_fifo_full = 1'b0;
    test_reset();
    test_lit_and_shadow();
    test_none();
    test_reflect();
    test_clamp();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
